spi_cmd_slave: RTL and testbench

//  MCU-facing SPI slave (mode 0, MSB first, SSEL active-low) feeding the MCU command decoder.

---
 rtl/spi_cmd_slave.sv | 164 ++++++++++++++++
 tb/tb_spi_cmd_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: oversamples SCK/MOSI/SSEL in the clk domain, frames command/parameter
// bytes and shifts read data out on MISO. Define SPI_SCK_FILTER_EN for a glitch-filtered SCK edge.
module spi_cmd_slave #(
  parameter int unsigned BYTECNT_W  = 32,
  parameter int unsigned SYNC_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SCK,
  input  logic                 MOSI,
  input  logic                 SSEL,
  output logic                 MISO,
  input  logic [7:0]           input_data,
  output logic                 cmd_ready,
  output logic                 param_ready,
  output logic [7:0]           cmd_data,
  output logic [7:0]           param_data,
  output logic [BYTECNT_W-1:0] byte_cnt,
  output logic [2:0]           bit_cnt,
  output logic                 startmessage,
  output logic                 endmessage
);

`ifdef SPI_SCK_FILTER_EN
  localparam int unsigned SckDepth = SYNC_DEPTH + 1;
`else
  localparam int unsigned SckDepth = SYNC_DEPTH;
`endif

  // Synchroniser chains: bit 0 is the newest sample, the top bit the oldest.
  logic [SckDepth-1:0]   sck_sync_q, sck_sync_d;
  logic [SYNC_DEPTH-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_DEPTH-1:0] ssel_sync_q, ssel_sync_d;

  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [BYTECNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]           cmd_data_q, cmd_data_d;
  logic [7:0]           param_data_q, param_data_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 param_ready_q, param_ready_d;
  logic                 start_q, start_d;
  logic                 end_q, end_d;
  logic                 miso_q, miso_d;

  logic                 sck_rise, sck_fall;
  logic                 ssel_rise, ssel_fall, ssel_high;
  logic                 mosi_s;
  logic [7:0]           rx_byte;
  logic [BYTECNT_W-1:0] byte_cnt_inc;

  // Edge detection
`ifdef SPI_SCK_FILTER_EN
  // A new level must be seen on two consecutive samples before the edge is accepted.
  assign sck_rise = ({sck_sync_q[SckDepth-1], sck_sync_q[SckDepth-2], sck_sync_q[SckDepth-3]}
                     == 3'b011);
  assign sck_fall = ({sck_sync_q[SckDepth-1], sck_sync_q[SckDepth-2], sck_sync_q[SckDepth-3]}
                     == 3'b100);
`else
  assign sck_rise = ({sck_sync_q[SckDepth-1], sck_sync_q[SckDepth-2]} == 2'b01);
  assign sck_fall = ({sck_sync_q[SckDepth-1], sck_sync_q[SckDepth-2]} == 2'b10);
`endif

  assign ssel_rise = ({ssel_sync_q[SYNC_DEPTH-1], ssel_sync_q[SYNC_DEPTH-2]} == 2'b01);
  assign ssel_fall = ({ssel_sync_q[SYNC_DEPTH-1], ssel_sync_q[SYNC_DEPTH-2]} == 2'b10);
  // Newer stage so that an SSEL rise overrides an SCK edge seen in the same cycle.
  assign ssel_high = ssel_sync_q[SYNC_DEPTH-2];
  assign mosi_s    = mosi_sync_q[SYNC_DEPTH-1];

  always_comb begin
    sck_sync_d    = {sck_sync_q[SckDepth-2:0], SCK};
    mosi_sync_d   = {mosi_sync_q[SYNC_DEPTH-2:0], MOSI};
    ssel_sync_d   = {ssel_sync_q[SYNC_DEPTH-2:0], SSEL};

    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    cmd_data_d    = cmd_data_q;
    param_data_d  = param_data_q;
    cmd_ready_d   = 1'b0;
    param_ready_d = 1'b0;
    start_d       = ssel_fall;
    end_d         = ssel_rise;

    rx_byte       = {rx_shift_q[6:0], mosi_s};
    byte_cnt_inc  = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + BYTECNT_W'(1);

    if (ssel_high) begin
      // Deselected: drop any partial byte and restart framing.
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
      rx_shift_d = 8'd0;
      tx_shift_d = 8'd0;
    end else if (sck_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd0) begin
        tx_shift_d = input_data;
      end
      if (bit_cnt_q == 3'd7) begin
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_q == '0) begin
          cmd_ready_d = 1'b1;
          cmd_data_d  = rx_byte;
        end else begin
          param_ready_d = 1'b1;
          param_data_d  = rx_byte;
        end
      end
    end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    // Between bytes MISO previews the MSB of the byte about to be loaded.
    miso_d = (bit_cnt_q == 3'd0) ? input_data[7] : tx_shift_q[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      ssel_sync_q   <= '1;
      rx_shift_q    <= 8'd0;
      tx_shift_q    <= 8'd0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= '0;
      cmd_data_q    <= 8'd0;
      param_data_q  <= 8'd0;
      cmd_ready_q   <= 1'b0;
      param_ready_q <= 1'b0;
      start_q       <= 1'b0;
      end_q         <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ssel_sync_q   <= ssel_sync_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      cmd_data_q    <= cmd_data_d;
      param_data_q  <= param_data_d;
      cmd_ready_q   <= cmd_ready_d;
      param_ready_q <= param_ready_d;
      start_q       <= start_d;
      end_q         <= end_d;
      miso_q        <= miso_d;
    end
  end

  assign MISO         = miso_q;
  assign cmd_ready    = cmd_ready_q;
  assign param_ready  = param_ready_q;
  assign cmd_data     = cmd_data_q;
  assign param_data   = param_data_q;
  assign byte_cnt     = byte_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign startmessage = start_q;
  assign endmessage   = end_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: framing, MISO replies, aborts, reset, glitch and saturation.
module tb_spi_cmd_slave;

  localparam int unsigned BW = 4;
  localparam int          PH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          SCK, MOSI, SSEL;
  logic          MISO;
  logic [7:0]    input_data;
  logic          cmd_ready, param_ready;
  logic [7:0]    cmd_data, param_data;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    bit_cnt;
  logic          startmessage, endmessage;

  int errors = 0;
  int checks = 0;

  int            n_cmd = 0, n_par = 0, n_both = 0, n_start = 0, n_end = 0;
  logic [7:0]    last_cmd_data = 8'd0, last_par_data = 8'd0;
  logic [BW-1:0] last_cmd_cnt = '0, last_par_cnt = '0;

  spi_cmd_slave #(
    .BYTECNT_W (BW),
    .SYNC_DEPTH(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SCK         (SCK),
    .MOSI        (MOSI),
    .SSEL        (SSEL),
    .MISO        (MISO),
    .input_data  (input_data),
    .cmd_ready   (cmd_ready),
    .param_ready (param_ready),
    .cmd_data    (cmd_data),
    .param_data  (param_data),
    .byte_cnt    (byte_cnt),
    .bit_cnt     (bit_cnt),
    .startmessage(startmessage),
    .endmessage  (endmessage)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (cmd_ready) begin
      n_cmd++;
      last_cmd_data = cmd_data;
      last_cmd_cnt  = byte_cnt;
    end
    if (param_ready) begin
      n_par++;
      last_par_data = param_data;
      last_par_cnt  = byte_cnt;
    end
    if (cmd_ready && param_ready) n_both++;
    if (startmessage) n_start++;
    if (endmessage) n_end++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the top n bits of tx MSB first; MISO captured just before each SCK rise.
  task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = tx[i];
      wait_clk(PH);
      rx[i] = MISO;
      SCK = 1'b1;
      wait_clk(PH);
      SCK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(8, tx, rx);
  endtask

  task automatic sel(input logic lvl);
    SSEL = lvl;
    wait_clk(PH);
  endtask

  int         b_cmd, b_par, b_end, b_start;
  logic [7:0] rx, rx2, rx3;

  initial begin
    rst_n = 1'b0; SCK = 1'b0; MOSI = 1'b0; SSEL = 1'b1; input_data = 8'hA5;
    wait_clk(3);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_bytecnt", 32'(byte_cnt), 32'd0);
    check("rst_cmd_data", 32'(cmd_data), 32'd0);
    check("rst_strobes", 32'({cmd_ready, param_ready, startmessage, endmessage}), 32'd0);
    rst_n = 1'b1;
    wait_clk(6);

    // Command + one parameter
    b_cmd = n_cmd; b_par = n_par; b_end = n_end; b_start = n_start;
    sel(1'b0);
    spi_byte(8'h91, rx);
    spi_byte(8'h5A, rx);
    check("t1_bytecnt_in_msg", 32'(byte_cnt), 32'd2);
    sel(1'b1);
    check("t1_cmd_count", 32'(n_cmd - b_cmd), 32'd1);
    check("t1_cmd_data", 32'(last_cmd_data), 32'h91);
    check("t1_cmd_bytecnt", 32'(last_cmd_cnt), 32'd1);
    check("t1_par_count", 32'(n_par - b_par), 32'd1);
    check("t1_par_data", 32'(last_par_data), 32'h5A);
    check("t1_par_bytecnt", 32'(last_par_cnt), 32'd2);
    check("t1_start_count", 32'(n_start - b_start), 32'd1);
    check("t1_end_count", 32'(n_end - b_end), 32'd1);
    check("t1_bytecnt_after", 32'(byte_cnt), 32'd0);

    // MISO replies with input_data held at 0xA5
    input_data = 8'hA5;
    sel(1'b0);
    check("t2_miso_pre", 32'(MISO), 32'd1);
    spi_byte(8'h01, rx);
    spi_byte(8'h02, rx2);
    spi_byte(8'h03, rx3);
    sel(1'b1);
    check("t2_miso_byte2", 32'(rx2), 32'hA5);
    check("t2_miso_byte3", 32'(rx3), 32'hA5);

    // Abort after 5 bits, then a clean command
    input_data = 8'h3C;
    b_cmd = n_cmd; b_par = n_par;
    sel(1'b0);
    check("t3_miso_pre", 32'(MISO), 32'd0);
    spi_bits(5, 8'hC8, rx);
    check("t3_bitcnt_partial", 32'(bit_cnt), 32'd5);
    sel(1'b1);
    check("t3_no_strobe", 32'((n_cmd - b_cmd) + (n_par - b_par)), 32'd0);
    check("t3_bitcnt_clr", 32'(bit_cnt), 32'd0);
    check("t3_bytecnt_clr", 32'(byte_cnt), 32'd0);
    sel(1'b0);
    spi_byte(8'hF0, rx);
    sel(1'b1);
    check("t3_cmd_count", 32'(n_cmd - b_cmd), 32'd1);
    check("t3_cmd_data", 32'(last_cmd_data), 32'hF0);
    check("t3_cmd_bytecnt", 32'(last_cmd_cnt), 32'd1);

    // Reset pulse during bit 4 of a parameter byte
    sel(1'b0);
    spi_byte(8'h11, rx);
    spi_bits(4, 8'hFF, rx);
    check("t4_bitcnt_pre", 32'(bit_cnt), 32'd4);
    wait_clk(2);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_bitcnt", 32'(bit_cnt), 32'd0);
    check("t4_rst_bytecnt", 32'(byte_cnt), 32'd0);
    check("t4_rst_data", 32'({cmd_data, param_data}), 32'd0);
    check("t4_rst_miso", 32'(MISO), 32'd0);
    wait_clk(1);
    rst_n = 1'b1;
    sel(1'b1);
    b_cmd = n_cmd; b_par = n_par;
    sel(1'b0);
    spi_byte(8'h30, rx);
    sel(1'b1);
    check("t4_cmd_count", 32'(n_cmd - b_cmd), 32'd1);
    check("t4_par_count", 32'(n_par - b_par), 32'd0);
    check("t4_cmd_data", 32'(last_cmd_data), 32'h30);

    // 20-byte message with a 4-bit byte counter
    b_cmd = n_cmd; b_par = n_par;
    sel(1'b0);
    for (int k = 0; k < 20; k++) spi_byte(8'(k + 8'h40), rx);
    check("t6_bytecnt_sat", 32'(byte_cnt), 32'd15);
    sel(1'b1);
    check("t6_cmd_count", 32'(n_cmd - b_cmd), 32'd1);
    check("t6_par_count", 32'(n_par - b_par), 32'd19);
    check("t6_last_par_cnt", 32'(last_par_cnt), 32'd15);
    check("t6_last_par_data", 32'(last_par_data), 32'h53);
    check("never_both", 32'(n_both), 32'd0);

    // 1-clk SCK glitch during a low phase
    sel(1'b0);
    spi_bits(3, 8'hAA, rx);
    wait_clk(PH);
    SCK = 1'b1;
    wait_clk(1);
    SCK = 1'b0;
    wait_clk(PH);
`ifdef SPI_SCK_FILTER_EN
    check("t5_glitch_bitcnt", 32'(bit_cnt), 32'd3);
`else
    check("t5_glitch_bitcnt", 32'(bit_cnt), 32'd4);
`endif
    sel(1'b1);
    check("t5_bitcnt_clr", 32'(bit_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
